debug_scan_sequencer: RTL and testbench
=======================================

# debug_scan_sequencer

Controller that drives the `en`/`debug_config_in` port pair of the SNN debug multiplexer. In auto-scan mode it steps the mux through every membrane-potential slot and then the three spike layers. For each slot it captures the mux output and streams it as a sample over a valid/ready handshake to the debug pin driver. In manual mode it passes a host-selected config through with a single-cycle load.

## Interface
Parameters:
- `NUM_MP`, default 24: number of 5-bit membrane-potential slots (mux selects 0..NUM_MP-1).
- `SETTLE_CYCLES`, default 1, range 1..15: cycles waited after a load before the mux output is captured.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `mode`, in, 1: 0 = manual, 1 = auto-scan.
- `continuous`, in, 1: auto-scan restarts at the first slot after the last slot; sampled at the end of each frame.
- `start`, in, 1: pulse that begins an auto-scan frame when idle.
- `abort`, in, 1: pulse that terminates any activity.
- `manual_sel`, in, 8: config value used for a manual load.
- `manual_load`, in, 1: pulse that requests a manual load.
- `mux_data`, in, 8: debug multiplexer output.
- `out_ready`, in, 1: downstream accepts the sample.
- `debug_en`, out, 1: enable to the debug config register.
- `debug_config_out`, out, 8: config value to the debug config register.
- `sample_data`, out, 8: captured mux output.
- `sample_index`, out, 8: config value that produced `sample_data`.
- `sample_valid`, out, 1: sample available.
- `sample_first`, out, 1: qualifies the first sample of a frame.
- `sample_last`, out, 1: qualifies the last sample of a frame.
- `busy`, out, 1: state is not IDLE.
- `frame_count`, out, 8: count of completed frames, wraps 255 -> 0.

## Operation
- Scan order, one frame of NUM_MP+3 samples: configs 0..NUM_MP-1, then 0x1E (layer 1 spikes), 0x1F (layer 2), 0x20 (layer 3).
- State IDLE:
  - `mode`=1 and `start`: go to LOAD with the slot pointer at 0.
  - `mode`=0 and `manual_load`: go to MLOAD.
  - `start` is ignored in `mode`=0. `manual_load` is ignored in `mode`=1 and outside IDLE.
- MLOAD: `debug_en`=1, `debug_config_out`=`manual_sel` as registered from the request cycle. Next state is IDLE. No sample is produced.
- LOAD: `debug_en`=1, `debug_config_out`=config of the current slot. Next state is SETTLE with the settle counter at 0.
- SETTLE: the counter increments each cycle. On the cycle where the counter equals SETTLE_CYCLES-1:
  - register `mux_data` into `sample_data` and the slot config into `sample_index`;
  - set `sample_valid`;
  - go to PRESENT.
- PRESENT: `sample_valid`=1. `sample_data`, `sample_index`, `sample_first` and `sample_last` hold stable until `out_ready`=1 at a clock edge (transfer). On transfer:
  - Slot is not last: increment the pointer and go to LOAD.
  - Slot is last: increment `frame_count`. If `continuous`=1, reset the pointer to 0 and go to LOAD; otherwise go to IDLE.
- `sample_first` = `sample_valid` and pointer = 0. `sample_last` = `sample_valid` and pointer = NUM_MP+2.
- `abort` in any state: next state is IDLE and `sample_valid` drops.
  - An aborted frame does not increment `frame_count`.
  - The last loaded config remains in the debug register, because `debug_en` is not asserted.
  - `abort` wins over a simultaneous `start`, `manual_load` or transfer.
- `debug_en` is asserted only in LOAD and MLOAD, for exactly one cycle per load.
- Changing `mode` mid-frame has no effect until the FSM returns to IDLE.
- Reset values: all outputs 0, state IDLE, pointer 0, settle counter 0.
- Reset mid-operation returns everything to the reset values asynchronously.

## Timing
- `start` high in cycle T (IDLE): LOAD in T+1 (`debug_en`=1); the debug register updates at the end of T+1. SETTLE occupies T+2..T+1+SETTLE_CYCLES. `sample_valid` rises in T+2+SETTLE_CYCLES (T+3 for the default).
- With `out_ready` held at 1, each sample takes SETTLE_CYCLES+2 cycles (3 for the default). One frame at defaults is 27 samples, 81 cycles.
- Manual: `manual_load` in cycle T gives `debug_en`=1 in T+1, and `busy` returns to 0 in T+2.
- `busy`=1 in every state other than IDLE.
- No combinational path from `out_ready` or `mux_data` to any output.

## Test plan
- Single frame, defaults, `out_ready`=1, `mux_data` = config+0x40 modeled by the bench: `start` at cycle 0 -> first `sample_valid` at cycle 3 with index 0, data 0x40. Then 27 samples with indices 0..23, 0x1E, 0x1F, 0x20. `sample_first` only on index 0, `sample_last` only on 0x20. `frame_count`=1 and `busy`=0 afterwards.
- Backpressure: drop `out_ready` for 5 cycles during index 7 -> data and index held stable for those 5 cycles, no `debug_en` pulse. Index 8 is loaded in the cycle after the transfer.
- Continuous wrap with `continuous`=1 over 2 frames -> index 0x20 is followed directly by LOAD of index 0. `frame_count` goes 0 -> 1 -> 2. Clearing `continuous` during frame 2 ends in IDLE after index 0x20.
- Abort with a simultaneous transfer at index 10 -> IDLE next cycle, `sample_valid`=0, `frame_count` unchanged. A `start` asserted in the same cycle as `abort` is ignored.
- Manual: `mode`=0, `manual_sel`=0x05, `manual_load` pulse -> exactly one `debug_en` cycle with config 0x05 and no `sample_valid`. `start` in `mode`=0 produces no activity.
- Reset asserted mid-SETTLE with SETTLE_CYCLES=4 -> all outputs 0 immediately. A fresh `start` yields first valid 6 cycles later.

Source files
------------

// File: rtl/debug_scan_sequencer.sv
// debug_scan_sequencer
//   Drives the en/config port pair of the SNN debug multiplexer. Auto-scan mode
//   walks every membrane-potential slot followed by the three spike layers. It
//   captures the mux output for each slot and presents it as a valid/ready
//   sample. Manual mode performs a single load of a host-selected config.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   mode                0 = manual, 1 = auto-scan
//   continuous          restart at slot 0 after the last slot (sampled at frame end)
//   start               begin an auto-scan frame (IDLE, mode=1 only)
//   abort               terminate any activity
//   manual_sel          config used for a manual load
//   manual_load         request a manual load (IDLE, mode=0 only)
//   mux_data            debug multiplexer output
//   out_ready           downstream accepts the sample
//   debug_en            one-cycle load enable to the debug config register
//   debug_config_out    config value to the debug config register
//   sample_data         captured mux output
//   sample_index        config that produced sample_data
//   sample_valid        sample available
//   sample_first        sample is the first of a frame
//   sample_last         sample is the last of a frame
//   busy                sequencer not idle
//   frame_count         completed frames, wraps at 255
module debug_scan_sequencer #(
   parameter int unsigned NUM_MP        = 24,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic       continuous,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] manual_sel,
   input  logic       manual_load,
   input  logic [7:0] mux_data,
   input  logic       out_ready,
   output logic       debug_en,
   output logic [7:0] debug_config_out,
   output logic [7:0] sample_data,
   output logic [7:0] sample_index,
   output logic       sample_valid,
   output logic       sample_first,
   output logic       sample_last,
   output logic       busy,
   output logic [7:0] frame_count
);

   typedef enum logic [2:0] {IDLE, MLOAD, LOAD, SETTLE, PRESENT} state_t;

   localparam logic [7:0] MP_SLOTS    = 8'(NUM_MP);
   localparam logic [7:0] LAST_PTR    = 8'(NUM_MP + 2);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state, state_next;
   logic [7:0] ptr, ptr_next;
   logic [3:0] cnt, cnt_next;
   logic [7:0] manual_cfg;
   logic [7:0] slot_cfg;
   logic       capture, transfer, frame_done, mreq;

   // Slots past the membrane-potential range map onto the spike-layer configs 0x1E..0x20.
   always_comb begin
      if (ptr < MP_SLOTS) slot_cfg = ptr;
      else                slot_cfg = 8'h1E + (ptr - MP_SLOTS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      cnt_next   = cnt;
      capture    = 1'b0;
      transfer   = 1'b0;
      frame_done = 1'b0;
      mreq       = 1'b0;
      case (state)
         IDLE: begin
            if (mode && start) begin
               state_next = LOAD;
               ptr_next   = '0;
            end else if (!mode && manual_load) begin
               state_next = MLOAD;
               mreq       = 1'b1;
            end
         end
         MLOAD: state_next = IDLE;
         LOAD: begin
            state_next = SETTLE;
            cnt_next   = '0;
         end
         SETTLE: begin
            cnt_next = cnt + 4'd1;
            if (cnt == SETTLE_LAST) begin
               capture    = 1'b1;
               cnt_next   = '0;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               transfer = 1'b1;
               if (ptr == LAST_PTR) begin
                  frame_done = 1'b1;
                  ptr_next   = '0;
                  state_next = continuous ? LOAD : IDLE;
               end else begin
                  ptr_next   = ptr + 8'd1;
                  state_next = LOAD;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // Abort overrides every other event decided above, including a transfer.
      if (abort) begin
         state_next = IDLE;
         ptr_next   = '0;
         cnt_next   = '0;
         capture    = 1'b0;
         transfer   = 1'b0;
         frame_done = 1'b0;
         mreq       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         manual_cfg   <= '0;
         sample_data  <= '0;
         sample_index <= '0;
         sample_valid <= 1'b0;
         frame_count  <= '0;
      end else begin
         if (mreq) manual_cfg <= manual_sel;
         if (capture) begin
            sample_data  <= mux_data;
            sample_index <= slot_cfg;
            sample_valid <= 1'b1;
         end else if (transfer || abort) begin
            sample_valid <= 1'b0;
         end
         if (frame_done) frame_count <= frame_count + 8'd1;
      end
   end

   // Outputs are decoded from registered state only, so neither out_ready nor mux_data reaches them.
   always_comb begin
      debug_en         = 1'b0;
      debug_config_out = '0;
      if (state == LOAD) begin
         debug_en         = 1'b1;
         debug_config_out = slot_cfg;
      end else if (state == MLOAD) begin
         debug_en         = 1'b1;
         debug_config_out = manual_cfg;
      end
   end

   assign busy         = (state != IDLE);
   assign sample_first = sample_valid && (ptr == 8'd0);
   assign sample_last  = sample_valid && (ptr == LAST_PTR);

endmodule

// File: tb/tb_debug_scan_sequencer.sv
module tb_debug_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst, mode, continuous, start, abort, manual_load, out_ready;
   logic [7:0] manual_sel, mux_data, mux_data4;

   logic       debug_en, sample_valid, sample_first, sample_last, busy;
   logic [7:0] debug_config_out, sample_data, sample_index, frame_count;
   logic       debug_en4, sample_valid4, sample_first4, sample_last4, busy4;
   logic [7:0] debug_config_out4, sample_data4, sample_index4, frame_count4;

   logic [7:0] dbg_reg, dbg_reg4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   debug_scan_sequencer dut (
      .clk(clk), .rst(rst), .mode(mode), .continuous(continuous), .start(start),
      .abort(abort), .manual_sel(manual_sel), .manual_load(manual_load),
      .mux_data(mux_data), .out_ready(out_ready), .debug_en(debug_en),
      .debug_config_out(debug_config_out), .sample_data(sample_data),
      .sample_index(sample_index), .sample_valid(sample_valid),
      .sample_first(sample_first), .sample_last(sample_last), .busy(busy),
      .frame_count(frame_count)
   );

   debug_scan_sequencer #(.NUM_MP(24), .SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .mode(mode), .continuous(continuous), .start(start),
      .abort(abort), .manual_sel(manual_sel), .manual_load(manual_load),
      .mux_data(mux_data4), .out_ready(out_ready), .debug_en(debug_en4),
      .debug_config_out(debug_config_out4), .sample_data(sample_data4),
      .sample_index(sample_index4), .sample_valid(sample_valid4),
      .sample_first(sample_first4), .sample_last(sample_last4), .busy(busy4),
      .frame_count(frame_count4)
   );

   // Debug config register plus mux: the mux presents the selected config + 0x40.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_reg  <= '0;
         dbg_reg4 <= '0;
      end else begin
         if (debug_en)  dbg_reg  <= debug_config_out;
         if (debug_en4) dbg_reg4 <= debug_config_out4;
      end
   end
   assign mux_data  = dbg_reg  + 8'h40;
   assign mux_data4 = dbg_reg4 + 8'h40;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [7:0] exp_cfg(input int k);
      if (k < 24) return 8'(k);
      return 8'(8'h1E + (k - 24));
   endfunction

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!sample_valid && n < 20);
      chk({tag, " valid"}, 32'(sample_valid), 32'd1);
   endtask

   // Waits for sample k, then checks its content and framing flags.
   task automatic expect_sample(input int k, output int n);
      wait_valid($sformatf("s%0d", k), n);
      chk($sformatf("idx%0d", k),   32'(sample_index), 32'(exp_cfg(k)));
      chk($sformatf("data%0d", k),  32'(sample_data),  32'(exp_cfg(k) + 8'h40));
      chk($sformatf("first%0d", k), 32'(sample_first), 32'(k == 0));
      chk($sformatf("last%0d", k),  32'(sample_last),  32'(k == 26));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; mode = 1'b1; continuous = 1'b0; start = 1'b0; abort = 1'b0;
      manual_load = 1'b0; manual_sel = 8'h00; out_ready = 1'b1;
      tick();
      chk("rst busy",   32'(busy), 0);
      chk("rst en",     32'(debug_en), 0);
      chk("rst cfg",    32'(debug_config_out), 0);
      chk("rst valid",  32'(sample_valid), 0);
      chk("rst data",   32'(sample_data), 0);
      chk("rst index",  32'(sample_index), 0);
      chk("rst first",  32'(sample_first), 0);
      chk("rst last",   32'(sample_last), 0);
      chk("rst fcount", 32'(frame_count), 0);
      rst = 1'b0;
      tick();

      // Reset in the middle of SETTLE (4-cycle settle instance).
      start = 1'b1;
      tick(); start = 1'b0;
      chk("s4 load en", 32'(debug_en4), 1);
      tick(); tick();
      chk("s4 settle busy", 32'(busy4), 1);
      rst = 1'b1;
      #1;
      chk("s4 rst busy",  32'(busy4), 0);
      chk("s4 rst en",    32'(debug_en4), 0);
      chk("s4 rst valid", 32'(sample_valid4), 0);
      chk("s4 rst fc",    32'(frame_count4), 0);
      tick();
      rst = 1'b0;
      tick();
      start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick(); start = 1'b0;
         chk($sformatf("s4 novalid c%0d", c), 32'(sample_valid4), 0);
      end
      tick();
      chk("s4 valid c6", 32'(sample_valid4), 1);
      chk("s4 idx",      32'(sample_index4), 0);
      chk("s4 data",     32'(sample_data4), 32'h40);
      do_reset();

      // Single frame, defaults.
      start = 1'b1;
      tick(); start = 1'b0;
      chk("f1 load en",  32'(debug_en), 1);
      chk("f1 load cfg", 32'(debug_config_out), 0);
      tick();
      chk("f1 c2 valid", 32'(sample_valid), 0);
      for (int k = 0; k < 27; k++) begin
         expect_sample(k, n);
         chk($sformatf("f1 gap%0d", k), 32'(n), (k == 0) ? 32'd1 : 32'd3);
      end
      tick();
      chk("f1 busy", 32'(busy), 0);
      chk("f1 fc",   32'(frame_count), 1);

      // Backpressure on index 7.
      start = 1'b1;
      tick(); start = 1'b0;
      for (int k = 0; k < 8; k++) expect_sample(k, n);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bp valid%0d", c), 32'(sample_valid), 1);
         chk($sformatf("bp idx%0d", c),   32'(sample_index), 7);
         chk($sformatf("bp data%0d", c),  32'(sample_data), 32'h47);
         chk($sformatf("bp en%0d", c),    32'(debug_en), 0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp load8 en",  32'(debug_en), 1);
      chk("bp load8 cfg", 32'(debug_config_out), 8);
      for (int k = 8; k < 27; k++) expect_sample(k, n);
      tick();
      chk("bp busy", 32'(busy), 0);
      chk("bp fc",   32'(frame_count), 2);

      // Continuous over two frames, cleared during the second.
      continuous = 1'b1;
      start = 1'b1;
      tick(); start = 1'b0;
      for (int k = 0; k < 27; k++) expect_sample(k, n);
      tick();
      chk("ct wrap en",  32'(debug_en), 1);
      chk("ct wrap cfg", 32'(debug_config_out), 0);
      chk("ct fc1",      32'(frame_count), 3);
      for (int k = 0; k < 27; k++) begin
         expect_sample(k, n);
         if (k == 5) continuous = 1'b0;
      end
      tick();
      chk("ct busy", 32'(busy), 0);
      chk("ct fc2",  32'(frame_count), 4);

      // Abort with simultaneous transfer and start at index 10.
      start = 1'b1;
      tick(); start = 1'b0;
      for (int k = 0; k < 11; k++) expect_sample(k, n);
      abort = 1'b1; start = 1'b1;
      tick(); abort = 1'b0; start = 1'b0;
      chk("ab valid", 32'(sample_valid), 0);
      chk("ab busy",  32'(busy), 0);
      chk("ab en",    32'(debug_en), 0);
      chk("ab fc",    32'(frame_count), 4);
      chk("ab reg",   32'(dbg_reg), 10);
      tick();
      chk("ab start ignored", 32'(busy), 0);

      // Manual load, then start in manual mode.
      mode = 1'b0; manual_sel = 8'h05; manual_load = 1'b1;
      tick(); manual_load = 1'b0; manual_sel = 8'h77;
      chk("ml en",    32'(debug_en), 1);
      chk("ml cfg",   32'(debug_config_out), 5);
      chk("ml valid", 32'(sample_valid), 0);
      chk("ml busy",  32'(busy), 1);
      tick();
      chk("ml en off", 32'(debug_en), 0);
      chk("ml idle",   32'(busy), 0);
      chk("ml reg",    32'(dbg_reg), 5);
      start = 1'b1;
      tick(); start = 1'b0;
      chk("ms busy", 32'(busy), 0);
      chk("ms en",   32'(debug_en), 0);
      tick();
      chk("ms busy2", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
